// File: rtl/am2901_useq.sv
// am2901_useq -- microprogram sequencer for the Am2901 bit-slice.
//
// Holds a writable 2**AW x 32 control store and issues one microword per
// clock. Each word drives the slice (i, a, b, d, cin) for exactly one cycle
// and carries a sequencer op that picks the next address from the slice
// flags sampled in that same cycle.
//
// Microword layout:
//   [8:0] i   [12:9] a   [16:13] b   [20:17] d   [21] cin
//   [24:22] op   [28:25] tgt   [31:29] reserved
//
// Ports:
//   cp            clock, rising edge
//   rst           synchronous active-high reset (store is not cleared)
//   ld_en         store write strobe, honoured only while idle
//   ld_addr       store write address
//   ld_data       microword to write
//   start         run request, honoured only while idle and without ld_en
//   start_addr    address of the first microword
//   busy          high while a microword is being issued
//   done          one-cycle pulse after a HALT word executes
//   i, a, b, d    Am2901 opcode, register addresses, data
//   cin           Am2901 carry-in
//   z, cout, ovr  Am2901 flags for the word currently issued
//   o_dbg_state   1 while running
//   o_dbg_pc      address of the word currently held
//   o_dbg_ctr     loop counter
//
// Handshake: start/ld_en are level strobes sampled at a rising edge while
// idle; ld_en wins over start in the same cycle. During a run both are
// ignored. busy/done and every slice output are registered, so the flag
// inputs only reach the next-pc mux, never an output.

module am2901_useq #(
    parameter int AW = 4
) (
    input  logic          cp,
    input  logic          rst,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [31:0]   ld_data,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    output logic          busy,
    output logic          done,
    output logic [8:0]    i,
    output logic [3:0]    a,
    output logic [3:0]    b,
    output logic [3:0]    d,
    output logic          cin,
    input  logic          z,
    input  logic          cout,
    input  logic          ovr,
    output logic          o_dbg_state,
    output logic [AW-1:0] o_dbg_pc,
    output logic [3:0]    o_dbg_ctr
);

    localparam int DEPTH = 1 << AW;

    localparam logic [2:0] OP_CONT = 3'd0;
    localparam logic [2:0] OP_JMP  = 3'd1;
    localparam logic [2:0] OP_JZ   = 3'd2;
    localparam logic [2:0] OP_JC   = 3'd3;
    localparam logic [2:0] OP_LDCT = 3'd4;
    localparam logic [2:0] OP_RPCT = 3'd5;
    localparam logic [2:0] OP_HALT = 3'd6;
    localparam logic [2:0] OP_JOVR = 3'd7;

    // Idle word: i = 9'h040 (destination 001, no register/Q write), all
    // other fields zero.
    localparam logic [31:0] NOP_WORD = 32'h0000_0040;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t          r_state;
    logic [31:0]     r_store [DEPTH];
    logic [31:0]     r_uw;
    logic [AW-1:0]   r_pc;
    logic [3:0]      r_ctr;
    logic            r_busy;
    logic            r_done;

    logic [2:0]      w_op;
    logic [AW-1:0]   w_tgt;
    logic [AW-1:0]   w_pc_inc;
    logic [AW-1:0]   w_next_pc;
    logic [3:0]      w_next_ctr;
    logic            w_halt;
    logic            w_unused;

    assign w_op     = r_uw[24:22];
    assign w_tgt    = r_uw[25 +: AW];   // target bits above AW are dropped
    assign w_pc_inc = r_pc + AW'(1);    // wraps modulo 2**AW

    // Reserved bits and any target bits beyond AW carry no meaning.
    assign w_unused = ^{r_uw[31:29], r_uw[28:25]};

    // Next-pc / counter decision for the word issued this cycle. This is
    // the only place the slice flags enter the design.
    always_comb begin
        w_next_pc  = w_pc_inc;
        w_next_ctr = r_ctr;
        w_halt     = 1'b0;
        case (w_op)
            OP_CONT: w_next_pc = w_pc_inc;
            OP_JMP:  w_next_pc = w_tgt;
            OP_JZ:   if (z)    w_next_pc = w_tgt;
            OP_JC:   if (cout) w_next_pc = w_tgt;
            OP_LDCT: w_next_ctr = r_uw[20:17];
            OP_RPCT: begin
                // Counter stops at zero, so a body runs ctr+1 times.
                if (r_ctr != 4'd0) begin
                    w_next_ctr = r_ctr - 4'd1;
                    w_next_pc  = w_tgt;
                end
            end
            OP_HALT: w_halt = 1'b1;
            OP_JOVR: if (ovr)  w_next_pc = w_tgt;
            default: w_next_pc = w_pc_inc;
        endcase
    end

    // Control store: written from outside only while idle; rst leaves it.
    always_ff @(posedge cp) begin
        if (r_state == S_IDLE && ld_en) begin
            r_store[ld_addr] <= ld_data;
        end
    end

    // Sequencer FSM. The microword register is the output register: it is
    // loaded with the fetched word in RUN and with NOP_WORD in IDLE.
    always_ff @(posedge cp) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_uw    <= NOP_WORD;
            r_pc    <= '0;
            r_ctr   <= 4'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start && !ld_en) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                        r_pc    <= start_addr;
                        r_uw    <= r_store[start_addr];
                    end
                end
                S_RUN: begin
                    r_ctr <= w_next_ctr;
                    if (w_halt) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_uw    <= NOP_WORD;
                    end else begin
                        r_pc <= w_next_pc;
                        r_uw <= r_store[w_next_pc];
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_uw    <= NOP_WORD;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign i           = r_uw[8:0];
    assign a           = r_uw[12:9];
    assign b           = r_uw[16:13];
    assign d           = r_uw[20:17];
    assign cin         = r_uw[21];
    assign o_dbg_state = (r_state == S_RUN);
    assign o_dbg_pc    = r_pc;
    assign o_dbg_ctr   = r_ctr;

endmodule

// File: tb/tb_am2901_useq.sv
// Bench for am2901_useq: directed scenarios plus randomized programs,
// checked against a behavioural interpreter of the microword rules.

module tb_am2901_useq;

    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          cp;
    logic          rst;
    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [31:0]   ld_data;
    logic          start;
    logic [AW-1:0] start_addr;
    logic          busy;
    logic          done;
    logic [8:0]    i;
    logic [3:0]    a;
    logic [3:0]    b;
    logic [3:0]    d;
    logic          cin;
    logic          z;
    logic          cout;
    logic          ovr;
    logic          o_dbg_state;
    logic [AW-1:0] o_dbg_pc;
    logic [3:0]    o_dbg_ctr;

    am2901_useq #(.AW(AW)) dut (
        .cp(cp), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .start(start), .start_addr(start_addr), .busy(busy), .done(done),
        .i(i), .a(a), .b(b), .d(d), .cin(cin), .z(z), .cout(cout), .ovr(ovr),
        .o_dbg_state(o_dbg_state), .o_dbg_pc(o_dbg_pc), .o_dbg_ctr(o_dbg_ctr)
    );

    // ---------------- clock ----------------
    initial cp = 1'b0;
    always #5 cp = ~cp;

    // ---------------- model and bookkeeping ----------------
    logic [31:0] m_store [DEPTH];
    int          m_pc;
    int          m_ctr;
    int          n_tests;
    int          n_fail;
    logic [8:0]  obs_i [$];

    bit          force_en;
    bit          force_val;
    logic [3:0]  noise_addr;
    logic [31:0] noise_word;
    bit          noise_rand;

    function automatic logic [31:0] mk(input logic [8:0] fi, input logic [3:0] fa,
                                       input logic [3:0] fb, input logic [3:0] fd,
                                       input logic fc, input logic [2:0] op,
                                       input logic [3:0] tgt);
        return {3'b000, tgt, op, fc, fd, fb, fa, fi};
    endfunction

    // Bench-side interpretation of one issued word.
    function automatic bit model_step(input logic [31:0] w, input bit fz,
                                      input bit fcy, input bit fov);
        int op, tgt, nxt;
        op  = int'(w[24:22]);
        tgt = int'(w[28:25]) % DEPTH;
        nxt = (m_pc + 1) % DEPTH;
        case (op)
            0: m_pc = nxt;
            1: m_pc = tgt;
            2: m_pc = fz ? tgt : nxt;
            3: m_pc = fcy ? tgt : nxt;
            4: begin m_ctr = int'(w[20:17]); m_pc = nxt; end
            5: begin
                if (m_ctr > 0) begin m_ctr = m_ctr - 1; m_pc = tgt; end
                else m_pc = nxt;
            end
            6: return 1'b1;
            default: m_pc = fov ? tgt : nxt;
        endcase
        return 1'b0;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic load_word(input int addr, input logic [31:0] w);
        ld_en   = 1'b1;
        ld_addr = addr[AW-1:0];
        ld_data = w;
        @(negedge cp);
        ld_en   = 1'b0;
        m_store[addr] = w;
    endtask

    task automatic launch(input int sa);
        start      = 1'b1;
        start_addr = sa[AW-1:0];
        @(negedge cp);
        start      = 1'b0;
        m_pc       = sa;
    endtask

    // Checks every issued word against the model; returns at the done cycle.
    task automatic run_body(input int max_words, input bit noise,
                            output int n_issued, output bit halted);
        logic [31:0] w;
        bit fz, fcy, fov;
        n_issued = 0;
        halted   = 1'b0;
        obs_i.delete();
        while (!halted && n_issued < max_words) begin
            w = m_store[m_pc];
            obs_i.push_back(i);
            n_tests++;
            if (i !== w[8:0]) begin
                n_fail++;
                $display("FAIL run_i pc=%0d got %h exp %h", m_pc, i, w[8:0]);
            end
            n_tests++;
            if ({a, b, d, cin} !== {w[12:9], w[16:13], w[20:17], w[21]}) begin
                n_fail++;
                $display("FAIL run_fields pc=%0d got %h exp %h", m_pc,
                         {a, b, d, cin}, {w[12:9], w[16:13], w[20:17], w[21]});
            end
            n_tests++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL run_busy pc=%0d got busy=%b done=%b exp busy=1 done=0",
                         m_pc, busy, done);
            end
            if (force_en) begin
                fz = force_val; fcy = force_val; fov = force_val;
            end else begin
                fz  = 1'($urandom_range(0, 1));
                fcy = 1'($urandom_range(0, 1));
                fov = 1'($urandom_range(0, 1));
            end
            z = fz; cout = fcy; ovr = fov;
            if (noise) begin
                ld_en      = 1'($urandom_range(0, 1));
                start      = 1'($urandom_range(0, 1));
                ld_addr    = noise_rand ? 4'($urandom) : noise_addr;
                ld_data    = noise_rand ? $urandom : noise_word;
                start_addr = noise_rand ? 4'($urandom) : 4'd3;
            end
            halted = model_step(w, fz, fcy, fov);
            n_issued++;
            @(negedge cp);
        end
        ld_en = 1'b0;
        start = 1'b0;
        if (halted) begin
            n_tests++;
            if (busy !== 1'b0 || done !== 1'b1 ||
                {i, a, b, d, cin} !== {9'h040, 12'h000, 1'b0}) begin
                n_fail++;
                $display("FAIL done_cycle got busy=%b done=%b i=%h exp busy=0 done=1 i=040",
                         busy, done, i);
            end
            n_tests++;
            if (o_dbg_ctr !== 4'(m_ctr)) begin
                n_fail++;
                $display("FAIL ctr_after_run got %0d exp %0d", o_dbg_ctr, m_ctr);
            end
        end
    endtask

    task automatic finish_idle;
        @(negedge cp);
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 ||
            {i, a, b, d, cin} !== {9'h040, 12'h000, 1'b0}) begin
            n_fail++;
            $display("FAIL idle_after got busy=%b done=%b i=%h exp busy=0 done=0 i=040",
                     busy, done, i);
        end
    endtask

    task automatic apply_reset_check(input string tag);
        rst = 1'b1;
        ld_en = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge cp);
        rst = 1'b0;
        m_pc = 0;
        m_ctr = 0;
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (busy !== 1'b0 || done !== 1'b0 || o_dbg_ctr !== 4'd0 ||
                {i, a, b, d, cin} !== {9'h040, 12'h000, 1'b0}) begin
                n_fail++;
                $display("FAIL %s cyc%0d got busy=%b done=%b ctr=%0d i=%h exp 0/0/0/040",
                         tag, k, busy, done, o_dbg_ctr, i);
            end
            @(negedge cp);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        apply_reset_check("reset");
    endtask

    task automatic test_straight;
        int n; bit h;
        load_word(0, mk(9'h1C3, 4'h1, 4'h2, 4'h3, 1'b1, 3'd0, 4'h0));
        load_word(1, mk(9'h0C1, 4'h4, 4'h5, 4'h6, 1'b0, 3'd0, 4'h0));
        load_word(2, mk(9'h0A5, 4'h7, 4'h8, 4'h9, 1'b1, 3'd6, 4'h0));
        launch(0);
        run_body(10, 1'b0, n, h);
        n_tests++;
        if (obs_i.size() != 3 || obs_i[0] !== 9'h1C3 || obs_i[1] !== 9'h0C1 ||
            obs_i[2] !== 9'h0A5 || !h) begin
            n_fail++;
            $display("FAIL straight_seq got n=%0d halted=%0d exp 3 words 1C3 0C1 0A5",
                     obs_i.size(), h);
        end
        finish_idle();
    endtask

    task automatic test_loop;
        int n; bit h; int ones;
        load_word(0, mk(9'h003, 4'h0, 4'h0, 4'h3, 1'b0, 3'd4, 4'h0));
        load_word(1, mk(9'h111, 4'h1, 4'h1, 4'h0, 1'b1, 3'd5, 4'h1));
        load_word(2, mk(9'h022, 4'h2, 4'h2, 4'h0, 1'b0, 3'd6, 4'h0));
        launch(0);
        run_body(20, 1'b0, n, h);
        ones = 0;
        foreach (obs_i[k]) if (obs_i[k] === 9'h111) ones++;
        n_tests++;
        if (obs_i.size() != 6 || ones != 4 || o_dbg_ctr !== 4'd0) begin
            n_fail++;
            $display("FAIL loop got busy_cycles=%0d body=%0d ctr=%0d exp 6 4 0",
                     obs_i.size(), ones, o_dbg_ctr);
        end
        finish_idle();
    endtask

    task automatic test_branch;
        int n; bit h;
        logic [2:0] ops [3];
        ops[0] = 3'd2; ops[1] = 3'd3; ops[2] = 3'd7;
        load_word(1, mk(9'h101, 4'h0, 4'h0, 4'h0, 1'b0, 3'd6, 4'h0));
        load_word(5, mk(9'h105, 4'h0, 4'h0, 4'h0, 1'b0, 3'd6, 4'h0));
        for (int k = 0; k < 3; k++) begin
            load_word(0, mk(9'h0F0, 4'hA, 4'hB, 4'hC, 1'b1, ops[k], 4'h5));
            for (int f = 1; f >= 0; f--) begin
                force_en  = 1'b1;
                force_val = f[0];
                launch(0);
                run_body(10, 1'b0, n, h);
                force_en  = 1'b0;
                n_tests++;
                if (obs_i.size() != 2 || obs_i[1] !== (f == 1 ? 9'h105 : 9'h101)) begin
                    n_fail++;
                    $display("FAIL branch op=%0d flag=%0d got n=%0d i1=%h exp %h",
                             ops[k], f, obs_i.size(), obs_i.size() > 1 ? obs_i[1] : 9'h0,
                             f == 1 ? 9'h105 : 9'h101);
                end
                finish_idle();
            end
        end
    endtask

    task automatic test_wrap_ignore;
        int n; bit h;
        load_word(15, mk(9'h0AA, 4'h3, 4'h3, 4'h3, 1'b0, 3'd0, 4'h0));
        load_word(0,  mk(9'h155, 4'h5, 4'h5, 4'h5, 1'b1, 3'd6, 4'h0));
        noise_rand = 1'b0;
        noise_addr = 4'd0;
        noise_word = mk(9'h1FF, 4'h0, 4'h0, 4'h0, 1'b0, 3'd0, 4'h0);
        for (int r = 0; r < 2; r++) begin
            launch(15);
            run_body(10, r == 0, n, h);
            n_tests++;
            if (obs_i.size() != 2 || obs_i[1] !== 9'h155) begin
                n_fail++;
                $display("FAIL wrap run%0d got n=%0d i1=%h exp n=2 i1=155",
                         r, obs_i.size(), obs_i.size() > 1 ? obs_i[1] : 9'h0);
            end
            finish_idle();
        end
    endtask

    task automatic test_simul;
        int n; bit h; int busy_seen;
        load_word(0, mk(9'h0EE, 4'h0, 4'h0, 4'h0, 1'b0, 3'd1, 4'h0));
        ld_en = 1'b1; ld_addr = 4'd0;
        ld_data = mk(9'h123, 4'h1, 4'h2, 4'h3, 1'b1, 3'd6, 4'h0);
        start = 1'b1; start_addr = 4'd0;
        @(negedge cp);
        ld_en = 1'b0; start = 1'b0;
        m_store[0] = ld_data;
        busy_seen = 0;
        for (int k = 0; k < 3; k++) begin
            if (busy !== 1'b0 || i !== 9'h040) busy_seen++;
            @(negedge cp);
        end
        n_tests++;
        if (busy_seen != 0) begin
            n_fail++;
            $display("FAIL simul_no_run got active_cycles=%0d exp 0", busy_seen);
        end
        launch(0);
        run_body(5, 1'b0, n, h);
        n_tests++;
        if (obs_i.size() != 1 || obs_i[0] !== 9'h123 || !h) begin
            n_fail++;
            $display("FAIL simul_halt got n=%0d halted=%0d exp 1 word i=123", obs_i.size(), h);
        end
        finish_idle();
    endtask

    task automatic test_back_to_back;
        int n; bit h;
        load_word(3, mk(9'h033, 4'h3, 4'h0, 4'h1, 1'b0, 3'd0, 4'h0));
        load_word(4, mk(9'h044, 4'h4, 4'h0, 4'h2, 1'b1, 3'd6, 4'h0));
        load_word(7, mk(9'h077, 4'h7, 4'h0, 4'h3, 1'b0, 3'd6, 4'h0));
        launch(3);
        run_body(10, 1'b0, n, h);
        launch(7);            // start asserted during the done cycle
        run_body(10, 1'b0, n, h);
        n_tests++;
        if (obs_i.size() != 1 || obs_i[0] !== 9'h077 || !h) begin
            n_fail++;
            $display("FAIL back_to_back got n=%0d halted=%0d exp 1 word i=077", obs_i.size(), h);
        end
        finish_idle();
    endtask

    task automatic test_reset_midrun;
        int n; bit h;
        load_word(0, mk(9'h0B0, 4'h1, 4'h1, 4'h1, 1'b0, 3'd4, 4'h0)); // ctr <= 1
        load_word(1, mk(9'h0B1, 4'h2, 4'h2, 4'h2, 1'b0, 3'd1, 4'h1)); // spin
        launch(0);
        run_body(5, 1'b0, n, h);
        apply_reset_check("reset_midrun");
    endtask

    task automatic test_random;
        int n; bit h;
        noise_rand = 1'b1;
        for (int p = 0; p < 8; p++) begin
            for (int k = 0; k < DEPTH; k++) begin
                load_word(k, {3'($urandom), 4'($urandom),
                              ($urandom_range(0, 9) > 7) ? 3'd6 : 3'($urandom),
                              1'($urandom), 4'($urandom), 4'($urandom),
                              4'($urandom), 9'($urandom)});
            end
            launch(int'($urandom_range(0, DEPTH - 1)));
            run_body(40, 1'b1, n, h);
            if (h) finish_idle();
            else apply_reset_check("reset_random_abort");
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog timeout tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        n_tests = 0; n_fail = 0;
        rst = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        start = 1'b0; start_addr = '0; z = 1'b0; cout = 1'b0; ovr = 1'b0;
        force_en = 1'b0; force_val = 1'b0;
        noise_addr = '0; noise_word = '0; noise_rand = 1'b0;
        m_pc = 0; m_ctr = 0;
        foreach (m_store[k]) m_store[k] = 32'h0;
        @(negedge cp);
        test_reset();
        test_straight();
        test_loop();
        test_branch();
        test_wrap_ignore();
        test_simul();
        test_back_to_back();
        test_reset_midrun();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
